// File: rtl/countdown_timer_pkg.sv
// Shared types and helpers for the scaled countdown timer.
// The optional BCD output is enabled by defining COUNTDOWN_BCD_EN.
package countdown_timer_pkg;

    localparam int unsigned COUNT_W_DEF = 11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPaused,
        StExpired
    } timer_state_e;

    function automatic int unsigned calc_prescale(input int unsigned clk_hz,
                                                  input int unsigned scale_factor);
        return clk_hz / scale_factor;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the input stage, the timer and the display logic.
// The bcd field exists only when COUNTDOWN_BCD_EN is defined.
interface countdown_timer_if
    import countdown_timer_pkg::*;
#(
    parameter int unsigned COUNT_W = COUNT_W_DEF
) ();

    logic               start;
    logic               clear;
    logic               pause;
    logic [COUNT_W-1:0] start_value;
    logic [COUNT_W-1:0] count;
    logic               running;
    logic               done;
    logic               expired;
`ifdef COUNTDOWN_BCD_EN
    logic [15:0]        bcd;

    modport master (
        output start, clear, pause, start_value,
        input  count, running, done, expired, bcd
    );

    modport slave (
        input  start, clear, pause, start_value,
        output count, running, done, expired, bcd
    );
`else
    modport master (
        output start, clear, pause, start_value,
        input  count, running, done, expired
    );

    modport slave (
        input  start, clear, pause, start_value,
        output count, running, done, expired
    );
`endif

endinterface

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler for the countdown timer: counts enabled cycles and emits a one-cycle
// tick on the cycle that wraps from PRESCALE-1 back to 0.
module countdown_timer_tick_gen #(
    parameter int unsigned PRESCALE = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] Last = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        presc_d = presc_q;
        if (clr_i) begin
            presc_d = '0;
        end else if (en_i) begin
            presc_d = (presc_q == Last) ? '0 : presc_q + 1'b1;
        end
    end

    assign tick_o = en_i && !clr_i && (presc_q == Last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Scaled countdown engine: load on start, decrement once per prescaled unit,
// with pause/clear and expiry flags. Define COUNTDOWN_BCD_EN for a registered BCD view.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned SCALE_FACTOR = 1,
    parameter int unsigned COUNT_W      = COUNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    countdown_timer_if.slave        bus
);

    localparam int unsigned PRESCALE = calc_prescale(CLK_HZ, SCALE_FACTOR);

    timer_state_e       state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               running_q, running_d;
    logic               expired_q, expired_d;
    logic               done_q, done_d;
    logic               pend_q, pend_d;
    logic               presc_en;
    logic               presc_clr;
    logic               tick;

    // Prescaler advances in PAUSED too once pause drops, so resuming costs no cycle.
    assign presc_clr = bus.clear | bus.start;
    assign presc_en  = ((state_q == StRun) || (state_q == StPaused)) && !bus.pause;

    countdown_timer_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .en_i   (presc_en),
        .clr_i  (presc_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pend_d  = 1'b0;
        if (bus.clear) begin
            state_d = StIdle;
            count_d = '0;
        end else if (bus.start) begin
            if (bus.start_value == '0) begin
                state_d = StExpired;
                count_d = '0;
                pend_d  = 1'b1;
            end else begin
                state_d = StRun;
                count_d = bus.start_value;
            end
        end else begin
            unique case (state_q)
                StRun, StPaused: begin
                    if (bus.pause) begin
                        state_d = StPaused;
                    end else begin
                        state_d = StRun;
                        if (tick && (count_q != '0)) begin
                            count_d = count_q - 1'b1;
                            if (count_q == COUNT_W'(1)) begin
                                state_d = StExpired;
                                pend_d  = 1'b1;
                            end
                        end
                    end
                end
                StIdle, StExpired: ;
                default: state_d = StIdle;
            endcase
        end
        running_d = (state_d == StRun);
        expired_d = (state_d == StExpired);
        // done trails entry into EXPIRED by one cycle.
        done_d    = pend_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            running_q <= running_d;
            expired_q <= expired_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.done    = done_q;

`ifdef COUNTDOWN_BCD_EN
    function automatic logic [15:0] to_bcd(input logic [COUNT_W-1:0] bin);
        logic [15:0] acc;
        acc = '0;
        for (int i = int'(COUNT_W) - 1; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (acc[4*d +: 4] >= 4'd5) begin
                    acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
                end
            end
            acc = {acc[14:0], bin[i]};
        end
        return acc;
    endfunction

    logic [15:0] bcd_q, bcd_d;

    assign bcd_d = to_bcd(count_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q <= 16'h0000;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bus.bcd = bcd_q;
`endif

endmodule
